// File: rtl/sao_stat_ctrl.sv
// SAO statistics controller: walks the statistics window over one CTU and flags usable pixels.
// Define SAO_STAT_STALL_CNT_EN to add the saturating stall_cnt output.
module sao_stat_ctrl #(
  parameter int n_pix            = 4,
  parameter int org_window_width = 2,
  parameter int num_pix_CTU_log2 = 5
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        start,
  input  logic                        stall,
  input  logic [num_pix_CTU_log2-1:0] ctu_w_m1,
  input  logic [num_pix_CTU_log2-1:0] ctu_h_m1,
  input  logic [3:0]                  edge_avail,
  input  logic [1:0]                  eo_type,
  output logic                        en_o,
  output logic                        isWorking_stat,
  output logic                        isWorking_stat_r1,
  output logic                        not_end,
  output logic                        wait_forPre,
  output logic                        isToRefresh,
  output logic [n_pix-1:0]            b_use,
  output logic [num_pix_CTU_log2-1:0] x_pos,
  output logic [num_pix_CTU_log2-1:0] y_pos,
  output logic                        busy,
`ifdef SAO_STAT_STALL_CNT_EN
  output logic                        done,
  output logic [15:0]                 stall_cnt
`else
  output logic                        done
`endif
);

  localparam int W = num_pix_CTU_log2;
  localparam int H = n_pix / org_window_width;
  localparam logic [W-1:0] WW_STEP = W'(org_window_width);
  localparam logic [W-1:0] H_STEP  = W'(H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFRESH,
    S_SCAN,
    S_DRAIN
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ctu_w_q, ctu_w_d;
  logic [W-1:0] ctu_h_q, ctu_h_d;
  logic [3:0]   edge_q, edge_d;
  logic [1:0]   eo_q, eo_d;
  logic         drain_q, drain_d;
  logic         done_q, done_d;
  logic         work_r1_q, work_r1_d;

  logic         in_scan;
  logic         last_col;
  logic         last_row;
  logic         last_win;
  logic [W:0]   x_end;
  logic [W:0]   y_end;

  // Extra bit on the end-of-row/column sums so x_pos+step never wraps.
  assign x_end    = {1'b0, x_q} + {1'b0, WW_STEP};
  assign y_end    = {1'b0, y_q} + {1'b0, H_STEP};
  assign last_col = x_end > {1'b0, ctu_w_q};
  assign last_row = y_end > {1'b0, ctu_h_q};
  assign last_win = last_col & last_row;
  assign in_scan  = (state_q == S_SCAN);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    ctu_w_d   = ctu_w_q;
    ctu_h_d   = ctu_h_q;
    edge_d    = edge_q;
    eo_d      = eo_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    work_r1_d = work_r1_q;
    if (en_o) begin
      work_r1_d = isWorking_stat;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REFRESH;
          ctu_w_d = ctu_w_m1;
          ctu_h_d = ctu_h_m1;
          edge_d  = edge_avail;
          eo_d    = eo_type;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_REFRESH: begin
        state_d = S_SCAN;
        x_d     = '0;
        y_d     = '0;
      end
      S_SCAN: begin
        if (!stall) begin
          if (last_win) begin
            state_d = S_DRAIN;
            x_d     = '0;
            y_d     = '0;
            drain_d = 1'b0;
          end else if (last_col) begin
            x_d = '0;
            y_d = y_q + H_STEP;
          end else begin
            x_d = x_q + WW_STEP;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drain_q) begin
            state_d = S_IDLE;
            drain_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            drain_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      ctu_w_q   <= '0;
      ctu_h_q   <= '0;
      edge_q    <= '0;
      eo_q      <= '0;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
      work_r1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ctu_w_q   <= ctu_w_d;
      ctu_h_q   <= ctu_h_d;
      edge_q    <= edge_d;
      eo_q      <= eo_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      work_r1_q <= work_r1_d;
    end
  end

  // Per-pixel mask: inside the CTU, and EO neighbours present across CTU borders.
  for (genvar gi = 0; gi < n_pix; gi++) begin : g_pix
    localparam logic [W:0] COL_OFF = (W+1)'(gi % org_window_width);
    localparam logic [W:0] ROW_OFF = (W+1)'(gi / org_window_width);
    logic [W:0] col;
    logic [W:0] row;
    logic       in_ctu;
    logic       hor_ok;
    logic       ver_ok;
    assign col    = {1'b0, x_q} + COL_OFF;
    assign row    = {1'b0, y_q} + ROW_OFF;
    assign in_ctu = (col <= {1'b0, ctu_w_q}) & (row <= {1'b0, ctu_h_q});
    assign hor_ok = (eo_q == 2'd1) |
                    (((col != '0) | edge_q[0]) & ((col != {1'b0, ctu_w_q}) | edge_q[1]));
    assign ver_ok = (eo_q == 2'd0) |
                    (((row != '0) | edge_q[2]) & ((row != {1'b0, ctu_h_q}) | edge_q[3]));
    assign b_use[gi] = in_scan & in_ctu & hor_ok & ver_ok;
  end

  assign en_o              = ~stall;
  assign busy              = (state_q != S_IDLE);
  assign isToRefresh       = (state_q == S_REFRESH);
  assign isWorking_stat    = in_scan & ~stall;
  assign wait_forPre       = in_scan & stall;
  assign not_end           = in_scan & ~(last_win & ~stall);
  assign isWorking_stat_r1 = work_r1_q;
  assign x_pos             = x_q;
  assign y_pos             = y_q;
  assign done              = done_q;

`ifdef SAO_STAT_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_REFRESH) begin
      stall_cnt_d = '0;
    end else if (in_scan && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sao_stat_ctrl.sv
// Self-checking bench for sao_stat_ctrl: table of CTU runs checked cycle by cycle
// against a window scoreboard, plus a mid-scan reset sequence.
module tb_sao_stat_ctrl;

  logic       clk;
  logic       arst_n;
  logic       start;
  logic       stall;
  logic [4:0] ctu_w_m1;
  logic [4:0] ctu_h_m1;
  logic [3:0] edge_avail;
  logic [1:0] eo_type;
  logic       en_o;
  logic       isWorking_stat;
  logic       isWorking_stat_r1;
  logic       not_end;
  logic       wait_forPre;
  logic       isToRefresh;
  logic [3:0] b_use;
  logic [4:0] x_pos;
  logic [4:0] y_pos;
  logic       busy;
  logic       done;
`ifdef SAO_STAT_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  sao_stat_ctrl #(
    .n_pix            (4),
    .org_window_width (2),
    .num_pix_CTU_log2 (5)
  ) dut (
    .clk               (clk),
    .arst_n            (arst_n),
    .start             (start),
    .stall             (stall),
    .ctu_w_m1          (ctu_w_m1),
    .ctu_h_m1          (ctu_h_m1),
    .edge_avail        (edge_avail),
    .eo_type           (eo_type),
    .en_o              (en_o),
    .isWorking_stat    (isWorking_stat),
    .isWorking_stat_r1 (isWorking_stat_r1),
    .not_end           (not_end),
    .wait_forPre       (wait_forPre),
    .isToRefresh       (isToRefresh),
    .b_use             (b_use),
    .x_pos             (x_pos),
    .y_pos             (y_pos),
    .busy              (busy),
`ifdef SAO_STAT_STALL_CNT_EN
    .done              (done),
    .stall_cnt         (stall_cnt)
`else
    .done              (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] w;
    logic [4:0] h;
    logic [3:0] e;
    logic [1:0] eo;
    int         stallAt;
    int         stallLen;
    int         expDone;
    int         expStallCnt;
  } vec_t;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [3:0] b;
  } win_t;

  typedef enum {M_IDLE, M_REF, M_SCAN, M_DRAIN, M_DONE} mstate_e;

  vec_t vecs[8];
  win_t sb[$];
  int   checkCount = 0;
  int   passCount  = 0;
  logic expR1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference pixel mask for a 2x2 window at (x,y).
  function automatic logic [3:0] refBuse(input int x, input int y, input vec_t v);
    logic [3:0] r;
    int c;
    int rw;
    bit ok;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      c  = x + (i % 2);
      rw = y + (i / 2);
      ok = (c <= int'(v.w)) && (rw <= int'(v.h));
      if (v.eo != 2'd1) begin
        if (c == 0 && !v.e[0]) ok = 1'b0;
        if (c == int'(v.w) && !v.e[1]) ok = 1'b0;
      end
      if (v.eo != 2'd0) begin
        if (rw == 0 && !v.e[2]) ok = 1'b0;
        if (rw == int'(v.h) && !v.e[3]) ok = 1'b0;
      end
      r[i] = ok;
    end
    return r;
  endfunction

  task automatic applyStimulus(input int cyc, input vec_t v);
    start = (cyc == 0) || (((cyc % 7) == 3) && (cyc < v.expDone));
    stall = (cyc >= v.stallAt) && (cyc < v.stallAt + v.stallLen);
    if (cyc == 0) begin
      ctu_w_m1   = v.w;
      ctu_h_m1   = v.h;
      edge_avail = v.e;
      eo_type    = v.eo;
    end else begin
      ctu_w_m1   = 5'($urandom);
      ctu_h_m1   = 5'($urandom);
      edge_avail = 4'($urandom);
      eo_type    = 2'($urandom);
    end
  endtask

  task automatic runCtu(input int idx);
    vec_t    v;
    mstate_e ms;
    int      drainCnt;
    win_t    w;
    win_t    expWin;
    logic    s;
    logic    eBusy, eRef, eWork, eWait, eNe, eDone;
    v        = vecs[idx];
    ms       = M_IDLE;
    drainCnt = 0;
    sb.delete();
    for (int yy = 0; yy <= int'(v.h); yy += 2) begin
      for (int xx = 0; xx <= int'(v.w); xx += 2) begin
        w.x = 5'(xx);
        w.y = 5'(yy);
        w.b = refBuse(xx, yy, v);
        sb.push_back(w);
      end
    end
    for (int cyc = 0; cyc <= v.expDone + 1; cyc++) begin
      @(negedge clk);
      applyStimulus(cyc, v);
      #1;
      s      = stall;
      eBusy  = (ms == M_REF) || (ms == M_SCAN) || (ms == M_DRAIN);
      eRef   = (ms == M_REF);
      eWork  = (ms == M_SCAN) && !s;
      eWait  = (ms == M_SCAN) && s;
      eNe    = (ms == M_SCAN) && !(!s && sb.size() == 1);
      eDone  = (ms == M_DONE);
      expWin = '0;
      if (ms == M_SCAN && sb.size() > 0) expWin = sb[0];
      checkOutput($sformatf("ctrl v%0d c%0d", idx, cyc),
                  32'({busy, isToRefresh, isWorking_stat, isWorking_stat_r1,
                       wait_forPre, not_end, en_o, done}),
                  32'({eBusy, eRef, eWork, expR1, eWait, eNe, !s, eDone}));
      checkOutput($sformatf("window v%0d c%0d", idx, cyc),
                  32'({x_pos, y_pos, b_use}), 32'(expWin));
      if (idx == 0 && isWorking_stat && x_pos == 5'd30 && y_pos == 5'd30)
        checkOutput("last_window_not_end", 32'(not_end), 32'd0);
      if (idx == 1 && isWorking_stat && x_pos == 5'd2 && y_pos == 5'd0)
        checkOutput("buse_win_2_0", 32'(b_use), 32'h5);
      if (idx == 1 && isWorking_stat && x_pos == 5'd2 && y_pos == 5'd2)
        checkOutput("buse_win_2_2", 32'(b_use), 32'h1);
      if (idx == 2 && isWorking_stat && x_pos == 5'd0 && y_pos == 5'd0)
        checkOutput("buse_diag_corner", 32'(b_use), 32'h8);
      if (idx == 2 && isWorking_stat && x_pos == 5'd2 && y_pos == 5'd2)
        checkOutput("buse_diag_interior", 32'(b_use), 32'hF);
      if (cyc == v.expDone)
        checkOutput($sformatf("done_cycle v%0d", idx), 32'({done, busy}), 32'b10);
`ifdef SAO_STAT_STALL_CNT_EN
      if (cyc >= v.expDone)
        checkOutput($sformatf("stall_cnt v%0d c%0d", idx, cyc), 32'(stall_cnt), 32'(v.expStallCnt));
`endif
      if (!s) expR1 = eWork;
      case (ms)
        M_IDLE:  if (start) ms = M_REF;
        M_REF:   ms = M_SCAN;
        M_SCAN: begin
          if (!s) begin
            void'(sb.pop_front());
            if (sb.size() == 0) begin
              ms       = M_DRAIN;
              drainCnt = 0;
            end
          end
        end
        M_DRAIN: begin
          if (!s) begin
            drainCnt++;
            if (drainCnt == 2) ms = M_DONE;
          end
        end
        default: ms = M_IDLE;
      endcase
    end
  endtask

  initial begin
    int bad;
    //            w      h      edge    eo    stAt stLen done stallCnt
    vecs[0] = '{5'd31, 5'd31, 4'hF,    2'd0, 0,  0,  260, 0};
    vecs[1] = '{5'd2,  5'd2,  4'hF,    2'd0, 0,  0,  8,   0};
    vecs[2] = '{5'd7,  5'd7,  4'h0,    2'd2, 0,  0,  20,  0};
    vecs[3] = '{5'd7,  5'd7,  4'hF,    2'd1, 6,  5,  25,  5};
    vecs[4] = '{5'd0,  5'd0,  4'b0101, 2'd3, 0,  0,  5,   0};
    vecs[5] = '{5'd4,  5'd1,  4'b1010, 2'd1, 2,  2,  9,   2};
    vecs[6] = '{5'd31, 5'd0,  4'hF,    2'd2, 18, 3,  23,  0};
    vecs[7] = '{5'd3,  5'd3,  4'hF,    2'd0, 1,  1,  8,   0};

    arst_n     = 1'b0;
    start      = 1'b0;
    stall      = 1'b1;
    ctu_w_m1   = '0;
    ctu_h_m1   = '0;
    edge_avail = '0;
    eo_type    = '0;
    expR1      = 1'b0;
    #3;
    checkOutput("reset_outputs_stalled",
                32'({busy, isToRefresh, isWorking_stat, isWorking_stat_r1, wait_forPre,
                     not_end, en_o, done, x_pos, y_pos, b_use}), 32'd0);
    stall = 1'b0;
    #1;
    checkOutput("reset_en_o", 32'({en_o, busy, done}), 32'b100);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 8; i++) runCtu(i);

    // Abandon a CTU mid-scan with an asynchronous reset.
    @(negedge clk);
    start      = 1'b1;
    ctu_w_m1   = 5'd7;
    ctu_h_m1   = 5'd7;
    edge_avail = 4'hF;
    eo_type    = 2'd0;
    stall      = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("midscan_active", 32'({busy, isWorking_stat}), 32'b11);
    arst_n = 1'b0;
    stall  = 1'b1;
    #1;
    checkOutput("midscan_reset_outputs",
                32'({busy, isToRefresh, isWorking_stat, isWorking_stat_r1, wait_forPre,
                     not_end, en_o, done, x_pos, y_pos, b_use}), 32'd0);
    stall = 1'b0;
    #1;
    checkOutput("midscan_reset_en_o", 32'({en_o, busy, done}), 32'b100);
`ifdef SAO_STAT_STALL_CNT_EN
    checkOutput("midscan_reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;
    expR1  = 1'b0;
    bad    = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (done || busy) bad++;
    end
    checkOutput("no_done_after_reset", 32'(bad), 32'd0);

    runCtu(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sao_stat_ctrl.md
SAO_STAT_CTRL -- requirements
Module: sao_stat_ctrl

Interface
REQ-001 SHALL have parameter n_pix, default 4, meaning pixels per statistics window.
REQ-002 SHALL have parameter org_window_width, default 2, meaning window width in pixels; window height H = n_pix/org_window_width.
REQ-003 SHALL have parameter num_pix_CTU_log2, default 5, meaning log2 of the maximum CTU side (32).
REQ-004 SHALL have ports clk (in, 1, sole clock) and arst_n (in, 1, asynchronous active-low reset).
REQ-005 SHALL have inputs: start (1, begin CTU), stall (1, data not ready), ctu_w_m1 and ctu_h_m1 ([num_pix_CTU_log2-1:0], CTU width/height minus 1), edge_avail ([3:0], {B,T,R,L} neighbour available), eo_type ([1:0], 0 hor, 1 ver, 2/3 diagonal).
REQ-006 SHALL have outputs: en_o (1, pipeline enable), isWorking_stat (1), isWorking_stat_r1 (1), not_end (1), wait_forPre (1), isToRefresh (1), b_use ([n_pix-1:0]), x_pos and y_pos ([num_pix_CTU_log2-1:0], window origin), busy (1), done (1).

Function
REQ-007 SHALL implement FSM IDLE -> REFRESH -> SCAN -> DRAIN -> IDLE.
REQ-008 IDLE: start=1 -> REFRESH; start SHALL be ignored in every other state.
REQ-009 REFRESH: lasts exactly 1 cycle; isToRefresh=1; x_pos=y_pos=0; -> SCAN.
REQ-010 SCAN: on each cycle with stall=0, isWorking_stat=1 and the window advances: x_pos += org_window_width; if x_pos+org_window_width > ctu_w_m1 then x_pos=0, y_pos += H.
REQ-011 Last window: x_pos+org_window_width > ctu_w_m1 and y_pos+H > ctu_h_m1; on that non-stalled cycle not_end=0 (otherwise 1 in SCAN) and FSM -> DRAIN.
REQ-012 Stall in SCAN: position, state and not_end hold; isWorking_stat=0; wait_forPre=1.
REQ-013 en_o = ~stall in every state; isWorking_stat_r1 SHALL register isWorking_stat only when en_o=1.
REQ-014 DRAIN: 2 cycles with en_o=1 (matching the 2-stage sel pipeline); done=1 on the cycle leaving DRAIN (single pulse); -> IDLE.
REQ-015 busy=1 in REFRESH, SCAN and DRAIN.
REQ-016 b_use[i], with col = x_pos + i%org_window_width and row = y_pos + i/org_window_width: 1 only in SCAN with col<=ctu_w_m1 and row<=ctu_h_m1.
REQ-017 b_use[i] with eo_type 0 or 2/3: col=0 requires edge_avail[0]; col=ctu_w_m1 requires edge_avail[1].
REQ-018 b_use[i] with eo_type 1 or 2/3: row=0 requires edge_avail[2]; row=ctu_h_m1 requires edge_avail[3].
REQ-019 Partial windows (odd width/height) SHALL mask out-of-CTU pixels without generating an extra row or column.
REQ-020 ctu_w_m1, ctu_h_m1, edge_avail and eo_type SHALL be sampled at start and held internally until done.
REQ-021 Single-window CTU (ctu_w_m1 < org_window_width, ctu_h_m1 < H): first SCAN cycle is the last; not_end=0 on it.

Reset
REQ-022 arst_n=0 at any time SHALL force IDLE, counters to 0, and all outputs to 0 except en_o=~stall; any CTU in progress is abandoned and done is not pulsed.
REQ-023 After reset release the first accepted start SHALL take effect on the next clk edge.

Configuration
REQ-024 Macro SAO_STAT_STALL_CNT_EN defined: adds output stall_cnt [15:0], cleared in REFRESH, +1 per stalled SCAN cycle, saturating at 16'hFFFF, held after done.
REQ-025 Macro SAO_STAT_STALL_CNT_EN undefined: no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-026 ctu 32x32 (m1=31), no stall, start at t0 -> isToRefresh at t1, 256 SCAN cycles, not_end=0 on window (30,30), done at t1+259.
REQ-027 ctu_w_m1=2, ctu_h_m1=2, all edges available, eo_type 0 -> 4 windows; window (2,0) b_use=4'b0101, window (2,2) b_use=4'b0001.
REQ-028 edge_avail=4'b0000, eo_type 2, ctu 8x8 -> window (0,0) b_use=4'b1000; interior window (2,2) b_use=4'b1111.
REQ-029 stall=1 for 5 cycles mid-SCAN -> x_pos/y_pos frozen, wait_forPre=1, isWorking_stat=0, done delayed by 5; stall_cnt=5 with the macro defined.
REQ-030 arst_n pulsed low during SCAN -> outputs 0, no done pulse; a new start completes normally.
